ibex_csr_access_ctrl: RTL and testbench



---
 rtl/ibex_csr_access_ctrl.sv | 133 +++++++++++++
 tb/tb_ibex_csr_access_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_csr_access_ctrl.sv
// Requester-side sequencer that performs read-modify-write accesses on a shadowed CSR bank.
// Optional readback verification after each write is enabled by defining IBEX_CSR_ACCESS_VERIFY_EN.
`timescale 1ns/1ps
module ibex_csr_access_ctrl #(
    parameter int Width       = 32,
    parameter int AddrWidth   = 12,
    parameter int ErrCntWidth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_op_i,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [Width-1:0]       req_wdata_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [Width-1:0]       rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic [AddrWidth-1:0]   csr_addr_o,
    output logic                   csr_wr_en_o,
    output logic [Width-1:0]       csr_wr_data_o,
    input  logic [Width-1:0]       csr_rd_data_i,
    input  logic                   csr_rd_error_i,
    input  logic                   csr_illegal_i,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

`ifdef IBEX_CSR_ACCESS_VERIFY_EN
    typedef enum logic [2:0] {IDLE, READ, WRITE, CHECK, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, WRITE, RESP} state_t;
`endif

    state_t           state;
    logic [1:0]       op_q;
    logic [Width-1:0] wdata_q;
    logic [Width-1:0] old_q;
    logic             access_err;
    logic [Width-1:0] new_value;

    // Address space 0xC00-0xFFF is read-only, so any modifying op there fails.
    assign access_err = csr_illegal_i | csr_rd_error_i |
                        ((op_q != OpRead) && (csr_addr_o[AddrWidth-1 -: 2] == 2'b11));

    always_comb begin
        new_value = wdata_q;
        case (op_q)
            OpWrite: new_value = wdata_q;
            OpSet:   new_value = csr_rd_data_i | wdata_q;
            OpClear: new_value = csr_rd_data_i & ~wdata_q;
            default: new_value = wdata_q;
        endcase
    end

    assign req_ready_o = (state == IDLE) && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            op_q          <= OpRead;
            wdata_q       <= '0;
            old_q         <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            csr_addr_o    <= '0;
            csr_wr_en_o   <= 1'b0;
            csr_wr_data_o <= '0;
            err_cnt_o     <= '0;
        end else begin
            csr_wr_en_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        op_q       <= req_op_i;
                        csr_addr_o <= req_addr_i;
                        wdata_q    <= req_wdata_i;
                        state      <= READ;
                    end
                end
                READ: begin
                    old_q <= csr_rd_data_i;
                    if (access_err || (op_q == OpRead)) begin
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= csr_rd_data_i;
                        rsp_err_o   <= access_err;
                        state       <= RESP;
                    end else begin
                        csr_wr_en_o   <= 1'b1;
                        csr_wr_data_o <= new_value;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
`ifdef IBEX_CSR_ACCESS_VERIFY_EN
                    state <= CHECK;
`else
                    rsp_valid_o <= 1'b1;
                    rsp_rdata_o <= old_q;
                    rsp_err_o   <= 1'b0;
                    state       <= RESP;
`endif
                end
`ifdef IBEX_CSR_ACCESS_VERIFY_EN
                // The bank now holds the new value; a differing readback means the write did not stick.
                CHECK: begin
                    rsp_valid_o <= 1'b1;
                    rsp_rdata_o <= old_q;
                    rsp_err_o   <= csr_rd_error_i | (csr_rd_data_i != csr_wr_data_o);
                    state       <= RESP;
                end
`endif
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                        if (rsp_err_o && (err_cnt_o != '1)) begin
                            err_cnt_o <= err_cnt_o + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_csr_access_ctrl.sv
// Self-checking bench for ibex_csr_access_ctrl: per-cycle transaction model plus directed literal checks.
// Build with IBEX_CSR_ACCESS_VERIFY_EN defined to also exercise the readback check.
`timescale 1ns/1ps
module tb_ibex_csr_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [11:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [11:0] csr_addr_o;
    logic        csr_wr_en_o;
    logic [31:0] csr_wr_data_o;
    logic [31:0] csr_rd_data_i;
    logic        csr_rd_error_i;
    logic        csr_illegal_i;
    logic [7:0]  err_cnt_o;

`ifdef IBEX_CSR_ACCESS_VERIFY_EN
    localparam int VerifyExtra = 1;
`else
    localparam int VerifyExtra = 0;
`endif
    localparam int WrLat = 3 + VerifyExtra;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    logic [31:0] last_wr = '0;
    logic [31:0] bank [0:4095];
    logic        force_rb;
    logic [31:0] force_val;

    // Behavioural model of the one outstanding transaction
    logic [31:0] m_mem [0:4095];
    bit          m_busy = 0;
    bit          m_write;
    bit          m_err;
    int          m_acc_cyc;
    int          m_rsp_cyc;
    logic [11:0] m_addr;
    logic [31:0] m_old;
    logic [31:0] m_new;
    logic [7:0]  m_cnt = '0;

    ibex_csr_access_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .csr_addr_o(csr_addr_o), .csr_wr_en_o(csr_wr_en_o), .csr_wr_data_o(csr_wr_data_o),
        .csr_rd_data_i(csr_rd_data_i), .csr_rd_error_i(csr_rd_error_i),
        .csr_illegal_i(csr_illegal_i), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    assign csr_rd_data_i = force_rb ? force_val : bank[csr_addr_o];

    function automatic logic [31:0] initVal(input int a);
        if (a == 'h300) return 32'h0000_1800;
        if (a == 'h340) return 32'hFFFF_FFFF;
        return 32'h0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // CSR bank environment: preloaded during reset, updated by DUT strobes
    initial begin
        forever begin
            @(posedge clk_i);
            cyc <= cyc + 1;
            if (rst_i) begin
                for (int i = 0; i < 4096; i++) bank[i] <= initVal(i);
            end else if (csr_wr_en_o) begin
                bank[csr_addr_o] <= csr_wr_data_o;
                strobe_cnt       <= strobe_cnt + 1;
                last_wr          <= csr_wr_data_o;
            end
        end
    end

    // Compare process: checks every output each cycle, then advances the model
    initial begin
        bit exp_ready, exp_valid, exp_strobe, pre_err;
        logic [31:0] rb;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                checkOutput("rst_req_ready", req_ready_o, 0);
                checkOutput("rst_rsp_valid", rsp_valid_o, 0);
                checkOutput("rst_wr_en", csr_wr_en_o, 0);
                checkOutput("rst_err_cnt", err_cnt_o, 0);
                m_busy = 0;
                m_cnt  = '0;
                for (int i = 0; i < 4096; i++) m_mem[i] = initVal(i);
            end else begin
                exp_ready  = !m_busy;
                exp_valid  = m_busy && (cyc >= m_rsp_cyc);
                exp_strobe = m_busy && m_write && (cyc == m_acc_cyc + 2);
                checkOutput("req_ready", req_ready_o, exp_ready);
                checkOutput("rsp_valid", rsp_valid_o, exp_valid);
                checkOutput("wr_en", csr_wr_en_o, exp_strobe);
                checkOutput("err_cnt", err_cnt_o, m_cnt);
                if (exp_strobe) checkOutput("wr_data", csr_wr_data_o, m_new);
                if (exp_valid) begin
                    checkOutput("rsp_rdata", rsp_rdata_o, m_old);
                    checkOutput("rsp_err", rsp_err_o, m_err);
                end
                if (m_busy && cyc > m_acc_cyc) checkOutput("csr_addr", csr_addr_o, m_addr);

                if (exp_strobe) m_mem[m_addr] = m_new;
                if (exp_valid && rsp_ready_i) begin
                    if (m_err && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                    m_busy = 0;
                end else if (exp_ready && req_valid_i) begin
                    m_busy    = 1;
                    m_acc_cyc = cyc;
                    m_addr    = req_addr_i;
                    m_old     = force_rb ? force_val : m_mem[req_addr_i];
                    pre_err   = csr_illegal_i || csr_rd_error_i ||
                                (req_op_i != 2'd0 && req_addr_i[11:10] == 2'b11);
                    case (req_op_i)
                        2'd1:    m_new = req_wdata_i;
                        2'd2:    m_new = m_old | req_wdata_i;
                        2'd3:    m_new = m_old & ~req_wdata_i;
                        default: m_new = m_old;
                    endcase
                    m_write   = !pre_err && req_op_i != 2'd0;
                    m_err     = pre_err;
                    rb        = force_rb ? force_val : m_new;
                    if (m_write && VerifyExtra == 1 && rb != m_new) m_err = 1;
                    m_rsp_cyc = m_write ? cyc + WrLat : cyc + 2;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                                 input logic ill, input logic rderr, input int hold,
                                 output logic [31:0] rdata, output logic err, output int lat, output int strobes);
        int  acc, start;
        bit  got;
        @(posedge clk_i); #1;
        csr_illegal_i  = ill;
        csr_rd_error_i = rderr;
        req_op_i       = op;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_valid_i    = 1'b1;
        rsp_ready_i    = 1'b0;
        start          = strobe_cnt;
        @(negedge clk_i);
        acc = cyc;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) got = 1;
        end
        lat = cyc - acc;
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL rsp_timeout: no rsp_valid_o within 40 cycles, required one");
        end
        repeat (hold) @(posedge clk_i);
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b1;
        rdata = rsp_rdata_o;
        err   = rsp_err_o;
        @(posedge clk_i); #1;
        rsp_ready_i    = 1'b0;
        csr_illegal_i  = 1'b0;
        csr_rd_error_i = 1'b0;
        strobes = strobe_cnt - start;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, st;
        rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_addr_i = '0; req_wdata_i = '0;
        rsp_ready_i = 1'b0; csr_rd_error_i = 1'b0; csr_illegal_i = 1'b0;
        force_rb = 1'b0; force_val = '0;
        repeat (3) @(posedge clk_i); #1;
        checkOutput("reset_req_ready", req_ready_o, 0);
        checkOutput("reset_rsp_valid", rsp_valid_o, 0);
        checkOutput("reset_rsp_rdata", rsp_rdata_o, 0);
        checkOutput("reset_rsp_err", rsp_err_o, 0);
        checkOutput("reset_csr_addr", csr_addr_o, 0);
        checkOutput("reset_wr_data", csr_wr_data_o, 0);
        checkOutput("reset_err_cnt", err_cnt_o, 0);
        rst_i = 1'b0;

        applyStimulus(2'd0, 12'h300, 32'h0, 0, 0, 0, rd, er, lat, st);
        checkOutput("read_rdata", rd, 32'h0000_1800);
        checkOutput("read_err", er, 0);
        checkOutput("read_lat", lat, 2);
        checkOutput("read_strobes", st, 0);

        applyStimulus(2'd2, 12'h300, 32'h0000_0008, 0, 0, 0, rd, er, lat, st);
        checkOutput("set_rdata", rd, 32'h0000_1800);
        checkOutput("set_wr_data", last_wr, 32'h0000_1808);
        checkOutput("set_strobes", st, 1);
        checkOutput("set_lat", lat, WrLat);
        checkOutput("set_err", er, 0);

        applyStimulus(2'd3, 12'h340, 32'h0000_00F0, 0, 0, 0, rd, er, lat, st);
        checkOutput("clear_wr_data", last_wr, 32'hFFFF_FF0F);
        checkOutput("clear_rdata", rd, 32'hFFFF_FFFF);

        applyStimulus(2'd1, 12'hC00, 32'h1234_5678, 0, 0, 0, rd, er, lat, st);
        checkOutput("ro_err", er, 1);
        checkOutput("ro_strobes", st, 0);
        checkOutput("ro_lat", lat, 2);
        checkOutput("ro_err_cnt", err_cnt_o, 8'd1);

        applyStimulus(2'd1, 12'h7FF, 32'hDEAD_BEEF, 1, 0, 0, rd, er, lat, st);
        checkOutput("illegal_err", er, 1);
        checkOutput("illegal_strobes", st, 0);

        applyStimulus(2'd0, 12'h300, 32'h0, 0, 1, 0, rd, er, lat, st);
        checkOutput("rderr_err", er, 1);
        checkOutput("rderr_err_cnt", err_cnt_o, 8'd3);

        applyStimulus(2'd1, 12'h304, 32'hA5A5_0000, 0, 0, 10, rd, er, lat, st);
        checkOutput("hold_strobes", st, 1);
        checkOutput("hold_rdata", rd, 32'h0);
        checkOutput("hold_err", er, 0);
        checkOutput("hold_bank", bank[12'h304], 32'hA5A5_0000);

`ifdef IBEX_CSR_ACCESS_VERIFY_EN
        force_rb = 1'b1; force_val = 32'h0;
        applyStimulus(2'd1, 12'h301, 32'h0000_0005, 0, 0, 0, rd, er, lat, st);
        force_rb = 1'b0;
        checkOutput("verify_err", er, 1);
        checkOutput("verify_rdata", rd, 32'h0);
        checkOutput("verify_strobes", st, 1);
`endif

        for (int i = 0; i < 255; i++) begin
            applyStimulus(2'd0, 12'h001, 32'h0, 1, 0, 0, rd, er, lat, st);
        end
        checkOutput("sat_err_cnt", err_cnt_o, 8'hFF);

        // Reset lands in the WRITE cycle of a write to 0x305
        @(posedge clk_i); #1;
        req_op_i = 2'd1; req_addr_i = 12'h305; req_wdata_i = 32'h0000_1234; req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        checkOutput("pre_rst_wr_en", csr_wr_en_o, 1);
        rst_i = 1'b1;
        #1;
        checkOutput("midrst_wr_en", csr_wr_en_o, 0);
        repeat (2) @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        checkOutput("postrst_wr_en", csr_wr_en_o, 0);
        checkOutput("postrst_req_ready", req_ready_o, 1);
        checkOutput("postrst_rsp_valid", rsp_valid_o, 0);
        checkOutput("postrst_bank", bank[12'h305], 32'h0);

        applyStimulus(2'd0, 12'h305, 32'h0, 0, 0, 0, rd, er, lat, st);
        checkOutput("postrst_read_rdata", rd, 32'h0);
        checkOutput("postrst_err_cnt", err_cnt_o, 8'd0);

        repeat (2) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
